// File: rtl/ram_stream_dma_if.sv
`default_nettype none
// ============================================================================
// ram_stream_dma_if : command, byte-stream and RAM-pin bundle for ram_stream_dma
// Revision 1.0
// ============================================================================
interface ram_stream_dma_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_base;
    logic [7:0]        cmd_len;
    logic [DATA_W-1:0] cmd_key;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_base, cmd_len, cmd_key,
        input  in_valid, in_data, out_ready, ram_q,
        output cmd_ready, in_ready, out_valid, out_data, busy, done,
        output ram_addr, ram_data, ram_we
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_base, cmd_len, cmd_key,
        output in_valid, in_data, out_ready, ram_q,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done,
        input  ram_addr, ram_data, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/ram_stream_dma.sv
`default_nettype none
// ============================================================================
// ram_stream_dma : byte-stream <-> single-port RAM DMA; XOR_KEY_EN adds XOR key
// Revision 1.0
// ============================================================================
module ram_stream_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_stream_dma_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [7:0]        rem_issue_q, rem_issue_d;
    logic [7:0]        rem_out_q, rem_out_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              inflight_q;
    logic [DATA_W-1:0] w_key;
    logic              w_wr_fire;
    logic              w_issue;
    logic              w_pop;
    logic              w_out_valid;
    logic [2:0]        w_occ;

`ifdef XOR_KEY_EN
    logic [DATA_W-1:0] key_q, key_d;
    assign key_d = (state_q == IDLE && bus.cmd_valid) ? bus.cmd_key : key_q;
    always_ff @(posedge clk) begin
        if (!rst_n) key_q <= '0;
        else        key_q <= key_d;
    end
    assign w_key = key_q;
`else
    logic w_unused_key;
    assign w_unused_key = ^bus.cmd_key;
    assign w_key        = '0;
`endif

    assign w_out_valid = (state_q == READ) && (count_q != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // Occupancy after this cycle's pop; counting the pop keeps 1 byte/cycle.
    assign w_occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign count_d     = count_q + {1'b0, inflight_q} - {1'b0, w_pop};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rem_issue_d = rem_issue_q;
        rem_out_d   = rem_out_q;
        w_wr_fire   = 1'b0;
        w_issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_base;
                    rem_issue_d = bus.cmd_len;
                    rem_out_d   = bus.cmd_len;
                    if (bus.cmd_len == 8'd0) state_d = FIN;
                    else if (bus.cmd_dir)    state_d = READ;
                    else                     state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.in_valid) begin
                    w_wr_fire   = 1'b1;
                    last_addr_d = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_out_d   = rem_out_q - 8'd1;
                    if (rem_out_q == 8'd1) state_d = FIN;
                end
            end
            READ: begin
                if (rem_issue_q != 8'd0 && w_occ < 3'd2) begin
                    w_issue     = 1'b1;
                    last_addr_d = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_issue_d = rem_issue_q - 8'd1;
                end
                if (w_pop) begin
                    rem_out_d = rem_out_q - 8'd1;
                    if (rem_out_q == 8'd1) state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_issue_q <= '0;
            rem_out_q   <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rem_issue_q <= rem_issue_d;
            rem_out_q   <= rem_out_d;
            count_q     <= count_d;
            inflight_q  <= w_issue;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.ram_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.in_ready  = (state_q == WRITE);
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? (fifo_q[rd_ptr_q] ^ w_key) : '0;
    assign bus.ram_we    = w_wr_fire;
    assign bus.ram_addr  = (w_wr_fire || w_issue) ? addr_q : last_addr_q;
    assign bus.ram_data  = w_wr_fire ? (bus.in_data ^ w_key) : '0;
endmodule
`default_nettype wire

// File: tb/tb_ram_stream_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ram_stream_dma : directed bench for ram_stream_dma with a registered RAM
// Revision 1.0
// ============================================================================
module tb_ram_stream_dma;
    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    logic [7:0] mem [256];
    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    ram_stream_dma_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    ram_stream_dma #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM with registered read port
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic send_cmd(input logic dir, input logic [7:0] base,
                            input logic [7:0] len, input logic [7:0] key);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.cmd_key   = key;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.ram_we, bus.out_valid} !== 5'b10000) begin
            miss++;
            $display("FAIL reset_outputs: got rdy/busy/done/we/ov=%b, want 10000",
                     {bus.cmd_ready, bus.busy, bus.done, bus.ram_we, bus.out_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_clr = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.ram_we, bus.out_valid} !== 5'b10000) begin
            miss++;
            $display("FAIL reset_release: got rdy/busy/done/we/ov=%b, want 10000",
                     {bus.cmd_ready, bus.busy, bus.done, bus.ram_we, bus.out_valid});
        end
    endtask

    task automatic test_write();
        send_cmd(1'b0, 8'h00, 8'd6, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'(i + 1);
            @(negedge clk);
            vecs++;
            if ({bus.ram_we, bus.in_ready, bus.ram_addr, bus.ram_data, bus.done, bus.out_valid}
                !== {1'b1, 1'b1, 8'(i), 8'(i + 1), 1'b0, 1'b0}) begin
                miss++;
                $display("FAIL write_beat%0d: got we=%b rdy=%b addr=%h data=%h done=%b ov=%b, want we=1 rdy=1 addr=%h data=%h done=0 ov=0",
                         i, bus.ram_we, bus.in_ready, bus.ram_addr, bus.ram_data, bus.done,
                         bus.out_valid, 8'(i), 8'(i + 1));
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if ({bus.done, bus.ram_we, bus.busy} !== 3'b101) begin
            miss++;
            $display("FAIL write_done: got done/we/busy=%b, want 101", {bus.done, bus.ram_we, bus.busy});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vecs++;
        if ({bus.done, bus.cmd_ready} !== 2'b01) begin
            miss++;
            $display("FAIL write_idle: got done/rdy=%b, want 01", {bus.done, bus.cmd_ready});
        end
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (mem[i] !== 8'(i + 1)) begin
                miss++;
                $display("FAIL write_mem%0d: got %h, want %h", i, mem[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_read_full();
        logic       exp_v;
        logic       exp_done;
        logic [7:0] exp_d;
        bus.out_ready = 1'b1;
        send_cmd(1'b1, 8'h00, 8'd6, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            exp_v    = (k >= 3) && (k <= 8);
            exp_done = (k == 9);
            exp_d    = 8'(k - 2);
            vecs++;
            if (bus.out_valid !== exp_v || bus.done !== exp_done || bus.ram_we !== 1'b0 ||
                (exp_v && bus.out_data !== exp_d)) begin
                miss++;
                $display("FAIL read_full_cyc%0d: got ov=%b data=%h done=%b we=%b, want ov=%b data=%h done=%b we=0",
                         k, bus.out_valid, bus.out_data, bus.done, bus.ram_we, exp_v, exp_d, exp_done);
            end
        end
    endtask

    task automatic test_read_bp();
        int   got    = 0;
        int   dones  = 0;
        int   last_k = -10;
        int   done_k = -1;
        logic fin    = 1'b0;
        send_cmd(1'b1, 8'h00, 8'd6, 8'h00);
        for (int k = 1; k <= 60 && !fin; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.out_ready = ((k - 1) % 3 == 0);
            @(negedge clk);
            if (bus.done) begin
                dones++; fin = 1'b1; done_k = k;
            end
            if (bus.out_valid && bus.out_ready) begin
                vecs++;
                if (got >= 6 || bus.out_data !== 8'(got + 1)) begin
                    miss++;
                    $display("FAIL read_bp_byte%0d: got %h, want %h", got, bus.out_data, 8'(got + 1));
                end
                got++;
                last_k = k;
            end
        end
        vecs++;
        if (got != 6 || dones != 1 || done_k != last_k + 1) begin
            miss++;
            $display("FAIL read_bp_total: got bytes=%0d dones=%0d done_cyc=%0d last_pop=%0d, want bytes=6 dones=1 done_cyc=last_pop+1",
                     got, dones, done_k, last_k);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic test_wrap_zero();
        logic [7:0] dat [3];
        logic [7:0] adr [3];
        dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;
        adr[0] = 8'hFE; adr[1] = 8'hFF; adr[2] = 8'h00;
        send_cmd(1'b0, 8'hFE, 8'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = dat[i];
            @(negedge clk);
            vecs++;
            if ({bus.ram_we, bus.ram_addr, bus.ram_data} !== {1'b1, adr[i], dat[i]}) begin
                miss++;
                $display("FAIL wrap_beat%0d: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                         i, bus.ram_we, bus.ram_addr, bus.ram_data, adr[i], dat[i]);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (mem[adr[i]] !== dat[i]) begin
                miss++;
                $display("FAIL wrap_mem%0d: got %h, want %h", i, mem[adr[i]], dat[i]);
            end
        end
        send_cmd(1'b0, 8'h10, 8'd0, 8'h00);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        @(negedge clk);
        vecs++;
        if ({bus.done, bus.busy, bus.ram_we, bus.in_ready} !== 4'b1100) begin
            miss++;
            $display("FAIL zero_len_done: got done/busy/we/rdy=%b, want 1100",
                     {bus.done, bus.busy, bus.ram_we, bus.in_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        vecs++;
        if ({bus.done, bus.cmd_ready, bus.ram_we, mem[8'h10]} !== {3'b010, 8'h00}) begin
            miss++;
            $display("FAIL zero_len_idle: got done/rdy/we=%b mem10=%h, want 010 mem10=00",
                     {bus.done, bus.cmd_ready, bus.ram_we}, mem[8'h10]);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        send_cmd(1'b0, 8'h20, 8'd6, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'(8'h11 + i);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vecs++;
            if ({bus.cmd_ready, bus.busy, bus.done} !== 3'b100) begin
                miss++;
                $display("FAIL mid_reset_cyc%0d: got rdy/busy/done=%b, want 100",
                         k, {bus.cmd_ready, bus.busy, bus.done});
            end
            @(posedge clk); #1;
        end
        vecs++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h11121300) begin
            miss++;
            $display("FAIL mid_reset_mem: got %h%h%h%h, want 11121300",
                     mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
        end
    endtask

    task automatic test_xor();
        logic [7:0] exp_w;
        logic       seen = 1'b0;
`ifdef XOR_KEY_EN
        exp_w = 8'h5A;
`else
        exp_w = 8'h00;
`endif
        send_cmd(1'b0, 8'h40, 8'd1, 8'h5A);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h00;
        @(negedge clk);
        vecs++;
        if ({bus.ram_we, bus.ram_data} !== {1'b1, exp_w}) begin
            miss++;
            $display("FAIL xor_write: got we=%b data=%h, want we=1 data=%h", bus.ram_we, bus.ram_data, exp_w);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        send_cmd(1'b1, 8'h40, 8'd1, 8'h5A);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                vecs++;
                if (bus.out_data !== 8'h00) begin
                    miss++;
                    $display("FAIL xor_read: got %h, want 00", bus.out_data);
                end
            end
        end
        vecs++;
        if (!seen || mem[8'h40] !== exp_w) begin
            miss++;
            $display("FAIL xor_mem: got seen=%b mem40=%h, want seen=1 mem40=%h", seen, mem[8'h40], exp_w);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_clr       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_base  = 8'h00;
        bus.cmd_len   = 8'd0;
        bus.cmd_key   = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        bus.out_ready = 1'b1;
        test_reset();
        test_write();
        test_read_full();
        test_read_bp();
        test_wrap_zero();
        test_mid_reset();
        test_xor();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
`default_nettype wire
